// File: rtl/cache_pkg.sv
// Shared types and register-map constants for the cache control/status slave
// and its window-compare helper.
package cache_pkg;

  typedef enum logic [2:0] {
    NOP   = 3'd0,
    INIT  = 3'd1,
    CLEAR = 3'd2,
    WB    = 3'd3
  } cache_cmd_e;

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_ISSUE
  } fsm_state_e;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_WB     = 1;
  localparam int CTRL_CLR    = 2;
  localparam int CTRL_IRQ_EN = 3;
  localparam int CTRL_BUSY   = 8;
  localparam int CTRL_DONE   = 9;

  localparam int REG_CTRL    = 0;
  localparam int REG_STATUS  = 1;
  localparam int REG_REGION0 = 2;

endpackage

// File: rtl/cache_region_match.sv
// Single uncached-window compare: hits when enabled and base <= addr <= limit.
// A window whose base exceeds its limit can never hit.
module cache_region_match #(
  parameter int FW = 22
) (
  input  logic [FW-1:0] base,
  input  logic [FW-1:0] limit,
  input  logic          enable,
  input  logic [FW-1:0] addr,
  output logic          hit
);

  assign hit = enable && (addr >= base) && (addr <= limit);

endmodule

// File: rtl/cache_region_ctr.sv
// Cache control/status slave: programmable uncached windows, cache enable,
// and a queued write-back/clear command sequencer with done interrupt.
module cache_region_ctr
  import cache_pkg::*;
#(
  parameter int REGION_NUM = 4,
  parameter int GRAN_BITS  = 10
) (
  input  logic        clk,
  input  logic        rest,
  input  logic [31:0] s0_address,
  input  logic [3:0]  s0_byteEnable,
  input  logic        s0_read,
  output logic [31:0] s0_readData,
  input  logic        s0_write,
  input  logic [31:0] s0_writeData,
  output logic        s0_waitRequest,
  output logic        s0_readDataValid,
  input  logic [31:0] address,
  output logic        isIOAddrBlock,
  output logic        isEnableCache,
  output logic [2:0]  cmd,
  input  logic        cmd_ready,
  output logic        busy,
  output logic        irq
);

  localparam int ADDR_W = $clog2(2*REGION_NUM+2);
  localparam int FW     = 32 - GRAN_BITS;
  localparam logic [FW-1:0] RESET_FIELD = FW'(32'h8000_0000 >> GRAN_BITS);

  logic [ADDR_W-1:0]     idx;
  logic [31:0]           lane_mask;
  logic [31:0]           rd_word;
  logic                  en_q, irq_en_q, done_q, irq_q;
  logic                  pend_wb_q, pend_clr_q, pend_wb_n, pend_clr_n;
  logic                  done_n, irq_en_n, complete;
  logic                  ctrl_wr, req_wb, req_clr, done_w1c;
  fsm_state_e            state_q, state_n;
  cache_cmd_e            cmd_q, cmd_n;
  logic [FW-1:0]         base_q  [REGION_NUM];
  logic [FW-1:0]         limit_q [REGION_NUM];
  logic [REGION_NUM-1:0] ren_q, hit;
  logic [31:0]           read_data_q;
  logic                  read_valid_q;
  logic                  unused_bits;

  assign idx       = s0_address[ADDR_W+1:2];
  assign lane_mask = {{8{s0_byteEnable[3]}}, {8{s0_byteEnable[2]}},
                      {8{s0_byteEnable[1]}}, {8{s0_byteEnable[0]}}};

  assign ctrl_wr  = s0_write && (idx == ADDR_W'(REG_CTRL));
  assign req_wb   = ctrl_wr && s0_byteEnable[0] && s0_writeData[CTRL_WB];
  // Dropping EN from 1 to 0 must also flush the cache, so it queues a clear.
  assign req_clr  = ctrl_wr && s0_byteEnable[0] &&
                    (s0_writeData[CTRL_CLR] || (en_q && !s0_writeData[CTRL_EN]));
  assign done_w1c = ctrl_wr && s0_byteEnable[1] && s0_writeData[CTRL_DONE];
  assign irq_en_n = (ctrl_wr && s0_byteEnable[0]) ? s0_writeData[CTRL_IRQ_EN] : irq_en_q;
  assign done_n   = (done_q && !done_w1c) || complete;

  assign busy = (state_q != S_IDLE) || pend_wb_q || pend_clr_q;

  always_comb begin
    state_n    = state_q;
    cmd_n      = cmd_q;
    pend_wb_n  = pend_wb_q;
    pend_clr_n = pend_clr_q;
    complete   = 1'b0;
    case (state_q)
      S_INIT: begin
        if (cmd_ready) begin
          state_n = S_IDLE;
          cmd_n   = NOP;
        end
      end
      S_IDLE, S_ISSUE: begin
        complete = (state_q == S_ISSUE) && cmd_ready;
        // A completion re-enters selection on the same edge; write-back wins.
        if (state_q == S_IDLE || cmd_ready) begin
          if (pend_wb_q) begin
            state_n   = S_ISSUE;
            cmd_n     = WB;
            pend_wb_n = 1'b0;
          end else if (pend_clr_q) begin
            state_n    = S_ISSUE;
            cmd_n      = CLEAR;
            pend_clr_n = 1'b0;
          end else begin
            state_n = S_IDLE;
            cmd_n   = NOP;
          end
        end
      end
      default: begin
        state_n = S_INIT;
        cmd_n   = INIT;
      end
    endcase
    pend_wb_n  = pend_wb_n  || req_wb;
    pend_clr_n = pend_clr_n || req_clr;
  end

  always_ff @(posedge clk) begin
    if (!rest) begin
      state_q    <= S_INIT;
      cmd_q      <= INIT;
      pend_wb_q  <= 1'b0;
      pend_clr_q <= 1'b0;
      done_q     <= 1'b0;
      irq_q      <= 1'b0;
      irq_en_q   <= 1'b0;
      en_q       <= 1'b1;
    end else begin
      state_q    <= state_n;
      cmd_q      <= cmd_n;
      pend_wb_q  <= pend_wb_n;
      pend_clr_q <= pend_clr_n;
      done_q     <= done_n;
      irq_q      <= done_n && irq_en_n;
      irq_en_q   <= irq_en_n;
      if (ctrl_wr && s0_byteEnable[0]) en_q <= s0_writeData[CTRL_EN];
    end
  end

  always_ff @(posedge clk) begin
    if (!rest) begin
      for (int i = 0; i < REGION_NUM; i++) begin
        base_q[i]  <= RESET_FIELD;
        limit_q[i] <= RESET_FIELD;
        ren_q[i]   <= 1'b0;
      end
    end else if (s0_write) begin
      for (int i = 0; i < REGION_NUM; i++) begin
        if (idx == ADDR_W'(REG_REGION0 + 2*i)) begin
          base_q[i] <= (base_q[i] & ~lane_mask[31:GRAN_BITS]) |
                       (s0_writeData[31:GRAN_BITS] & lane_mask[31:GRAN_BITS]);
          if (s0_byteEnable[0]) ren_q[i] <= s0_writeData[0];
        end
        if (idx == ADDR_W'(REG_REGION0 + 2*i + 1)) begin
          limit_q[i] <= (limit_q[i] & ~lane_mask[31:GRAN_BITS]) |
                        (s0_writeData[31:GRAN_BITS] & lane_mask[31:GRAN_BITS]);
        end
      end
    end
  end

  always_comb begin
    rd_word = '0;
    if (idx == ADDR_W'(REG_CTRL)) begin
      rd_word[CTRL_EN]     = en_q;
      rd_word[CTRL_IRQ_EN] = irq_en_q;
      rd_word[CTRL_BUSY]   = busy;
      rd_word[CTRL_DONE]   = done_q;
    end else if (idx == ADDR_W'(REG_STATUS)) begin
      rd_word[4:0] = {pend_clr_q, pend_wb_q, cmd_q};
    end
    for (int i = 0; i < REGION_NUM; i++) begin
      if (idx == ADDR_W'(REG_REGION0 + 2*i))
        rd_word = {base_q[i], {(GRAN_BITS-1){1'b0}}, ren_q[i]};
      if (idx == ADDR_W'(REG_REGION0 + 2*i + 1))
        rd_word = {limit_q[i], {GRAN_BITS{1'b0}}};
    end
  end

  always_ff @(posedge clk) begin
    if (!rest) begin
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
    end else begin
      read_valid_q <= s0_read;
      if (s0_read) read_data_q <= rd_word;
    end
  end

  for (genvar g = 0; g < REGION_NUM; g++) begin : g_match
    cache_region_match #(.FW(FW)) u_match (
      .base   (base_q[g]),
      .limit  (limit_q[g]),
      .enable (ren_q[g]),
      .addr   (address[31:GRAN_BITS]),
      .hit    (hit[g])
    );
  end

  assign isIOAddrBlock    = address[31] || (|hit);
  assign isEnableCache    = en_q;
  assign cmd              = cmd_q;
  assign irq              = irq_q;
  assign s0_readData      = read_data_q;
  assign s0_readDataValid = read_valid_q;
  assign s0_waitRequest   = 1'b0;

  assign unused_bits = ^{s0_address, address[GRAN_BITS-1:0], s0_writeData, lane_mask};

endmodule

// File: doc/cache_region_ctr.md
Name: cache_region_ctr

Overview:
- Next-generation cache control/status slave with REGION_NUM programmable uncached (IO) address windows, each with its own enable bit, and byte-enable-aware register writes.
- Supports queued write-back and clear maintenance commands toward the cache core, with a busy/done status and a completion interrupt.
- Sits beside the data cache on the CPU-side bus. Drives the uncached-region decision and the cache enable. Issues maintenance commands over a cmd/cmd_ready handshake.

Parameters:
- REGION_NUM, 4, number of IO address windows (1..16).
- GRAN_BITS, 10, window granularity; address bits below GRAN_BITS are ignored in compares.
- ADDR_W, $clog2(2*REGION_NUM+2), register word-index width (derived, not overridable).

Ports:
- clk  in  1  clock
- rest  in  1  synchronous active-low reset
- s0_address  in  32  byte address, word index = s0_address[ADDR_W+1:2]
- s0_byteEnable  in  4  write byte lanes
- s0_read  in  1  read strobe
- s0_readData  out  32  read data
- s0_write  in  1  write strobe
- s0_writeData  in  32  write data
- s0_waitRequest  out  1  tied 0; every access accepted in its cycle
- s0_readDataValid  out  1  read data valid
- address  in  32  lookup address from cache
- isIOAddrBlock  out  1  lookup address is uncached
- isEnableCache  out  1  CTRL.EN
- cmd  out  3  maintenance command (cache_cmd_e)
- cmd_ready  in  1  cache core finished current cmd
- busy  out  1  command in flight or pending
- irq  out  1  DONE & IRQ_EN

Behaviour:
- Reset is synchronous: all state is loaded on a clk edge with rest=0, which includes reset asserted mid-command. Reset values:
  - readData=0, readDataValid=0, irq=0.
  - EN=1, IRQ_EN=0, DONE=0, pending=0.
  - Every region: base=0x8000_0000, limit=0x8000_0000, enable bit=0.
  - FSM=INIT, cmd=INIT, busy=1.
- Register map (word index):
  - 0 CTRL:
    - bit0 EN (RW).
    - bit1 WB (write-1 requests write-back, reads 0).
    - bit2 CLR (write-1 requests clear, reads 0).
    - bit3 IRQ_EN (RW).
    - bit8 BUSY (RO).
    - bit9 DONE (write-1-clear).
  - 1 STATUS (RO):
    - [2:0] current cmd.
    - [4:3] pending {clr,wb}.
  - 2+2i REGION_BASE[i]:
    - [31:GRAN_BITS] base.
    - bit0 region enable.
  - 3+2i REGION_LIMIT[i]: [31:GRAN_BITS] limit (inclusive).
  - Unimplemented bits read 0. Indices ≥ 2*REGION_NUM+2 read 0; writes to them are ignored.
- Writes:
  - Only lanes with s0_byteEnable set update their bits.
  - A CTRL command/clear bit takes effect only if its byte lane is enabled.
- Reads:
  - Data registered: s0_readData and s0_readDataValid=1 appear the cycle after s0_read.
  - readDataValid=0 otherwise; readData holds its last value.
  - Read and write in the same cycle to the same word: read returns the old value.
- Lookup (combinational, zero latency):
  - isIOAddrBlock = address[31] | OR over i of (en_i & base_i ≤ address[31:GRAN_BITS] ≤ limit_i).
  - Comparison is unsigned. A window with base > limit never hits.
- Clear triggers:
  - Writing CTRL.CLR=1.
  - Writing EN 1→0 (EN lane enabled, old EN=1) raises pend_clr.
- Write-back trigger: writing WB=1 raises pend_wb.
- Pending bits are sticky. A repeated request while pending merges; it does not queue twice.
- FSM states:
  - INIT: cmd=INIT held until cmd_ready, then →IDLE, cmd=NOP.
  - IDLE: if pend_wb → ISSUE with cmd=WB, clear pend_wb. Else if pend_clr → ISSUE with cmd=CLEAR, clear pend_clr. Else cmd=NOP.
    - Same-cycle request is visible next cycle: a write at cycle t gives cmd at t+2.
  - ISSUE: cmd held. On cmd_ready → DONE=1.
    - If any pending, go straight to IDLE selection in the same edge, so the next cmd appears one cycle after cmd_ready.
    - Otherwise → IDLE with cmd=NOP.
    - WB is always served before CLR.
- busy = (state≠IDLE) | pend_wb | pend_clr.
- DONE:
  - Set on each cmd_ready completion outside INIT.
  - A W1C write in the same cycle as a completion leaves DONE=1.
- irq = DONE & IRQ_EN, registered from the same edge as DONE.
- cmd_ready is ignored in IDLE.

Decomposition:
- Shared package cache_pkg:
  - typedef enum logic[2:0] cache_cmd_e {NOP=0, INIT=1, CLEAR=2, WB=3}.
  - CTRL bit-position localparams.
  - Register index localparams.
- Sub-module cache_region_match: one window compare (base, limit, enable, addr → hit). Instantiated REGION_NUM times via generate; the results are OR-reduced.

Test Plan:
- Reset, hold cmd_ready=0 for 5 cycles: cmd=INIT and busy=1 throughout. Pulse cmd_ready → next cycle cmd=NOP, busy=0, DONE=0.
- Program region1 base=0x0010_0400 (en=1), limit=0x0010_07FF. Drive address 0x0010_0400, 0x0010_07FC, 0x0010_0800, 0x8000_0000 → isIOAddrBlock 1, 1, 0, 1. Clear the enable → 0x0010_0400 gives 0.
- Write CTRL=0x0000_0007 (EN=1, WB, CLR): cmd=WB at t+2. cmd_ready → cmd=CLEAR the next cycle. cmd_ready → NOP, DONE=1, STATUS[4:3]=0.
- IRQ_EN=1, write EN=0 → cmd=CLEAR, isEnableCache=0. On completion irq=1. Write CTRL with bit9=1 → irq=0 the next cycle.
- While WB is in flight, write WB twice and CLR once → exactly one more WB, then one CLEAR. Assert reset mid-CLEAR → cmd=INIT, pending=0, all regions back to 0x8000_0000/disabled.
- Write CTRL 0x0000_0200 with byteEnable=4'b0001 → DONE is not cleared. Read index 2*REGION_NUM+2 → readData=0, readDataValid one cycle after s0_read.
